// File: rtl/rv32i_pkg.sv
// Shared types and lane helpers for the rv32i memory-access stage.
// Purely declarative: no state, no latency, no flow control.
package rv32i_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } wb_t;

    function automatic logic op_is_store(mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic op_is_byte(mem_op_t op);
        return op inside {MEM_LB, MEM_LBU, MEM_SB};
    endfunction

    function automatic logic op_is_half(mem_op_t op);
        return op inside {MEM_LH, MEM_LHU, MEM_SH};
    endfunction

    function automatic logic op_is_word(mem_op_t op);
        return op inside {MEM_LW, MEM_SW};
    endfunction

    function automatic logic op_is_mem(mem_op_t op);
        return op_is_byte(op) | op_is_half(op) | op_is_word(op);
    endfunction

    function automatic logic misaligned(mem_op_t op, logic [1:0] lo);
        return (op_is_half(op) && lo[0]) || (op_is_word(op) && (lo != 2'b00));
    endfunction

    function automatic logic [3:0] lane_be(mem_op_t op, logic [1:0] lo);
        if (op_is_byte(op)) return 4'b0001 << lo;
        if (op_is_half(op)) return 4'b0011 << lo;
        return 4'b1111;
    endfunction

    // Replicating the low lanes lets the byte enables pick the target lane.
    function automatic logic [31:0] lane_wdata(mem_op_t op, logic [31:0] sd);
        if (op_is_byte(op)) return {4{sd[7:0]}};
        if (op_is_half(op)) return {2{sd[15:0]}};
        return sd;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Selects the addressed byte/halfword of a load word and sign/zero extends it.
// Combinational, zero latency; no flow control.
module load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  mem_op_t     mem_op,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (mem_op)
            MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data = {24'd0, byte_sel};
            MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rv32i memory-access stage: loads/stores over a req/gnt/rvalid bus, registered writeback.
// Latency: 1 cycle for pass-through/misaligned, bus-dependent otherwise; TIMEOUT cycles max per phase.
// Backpressure: ready_out is low whenever a bus transaction is outstanding.
module mem_access
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_out,
    input  mem_op_t     mem_op,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    input  logic        reg_we_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] wb_data,
    output logic        misalign_exc,
    output logic        bus_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    mem_op_t     op_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  rd_q;
    logic        we_q;
    wb_t         wb_q;
    logic [31:0] load_val;

    logic start_req, fin_none, fin_mis, fin_store, fin_load, fin_tmo;

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (addr_lo_q),
        .mem_op  (op_q),
        .data    (load_val)
    );

    assign ready_out = (state == IDLE);
    assign wb_rd     = wb_q.rd;
    assign wb_we     = wb_q.we;
    assign wb_data   = wb_q.data;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Progress (gnt/rvalid) wins over the timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        start_req = 1'b0;
        fin_none  = 1'b0;
        fin_mis   = 1'b0;
        fin_store = 1'b0;
        fin_load  = 1'b0;
        fin_tmo   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    if (!op_is_mem(mem_op)) begin
                        fin_none = 1'b1;
                    end else if (misaligned(mem_op, alu_result[1:0])) begin
                        fin_mis = 1'b1;
                    end else begin
                        start_req = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (op_is_store(op_q)) begin
                        fin_store = 1'b1;
                        state_nxt = IDLE;
                    end else if (dmem_rvalid) begin
                        fin_load  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RESP;
                    end
                end else if (cnt == CNT_LAST) begin
                    fin_tmo   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    fin_load  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    fin_tmo   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= 8'd0;
        end else if (start_req || (state == REQ && state_nxt == RESP)) begin
            cnt <= 8'd0;
        end else if (state != IDLE) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q         <= MEM_NONE;
            addr_lo_q    <= 2'd0;
            rd_q         <= 5'd0;
            we_q         <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'd0;
            dmem_be      <= 4'd0;
            dmem_wdata   <= 32'd0;
            wb_valid     <= 1'b0;
            wb_q         <= '0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_exc <= 1'b0;
            bus_err      <= 1'b0;
            if (start_req) begin
                op_q       <= mem_op;
                addr_lo_q  <= alu_result[1:0];
                rd_q       <= rd_in;
                we_q       <= reg_we_in;
                dmem_req   <= 1'b1;
                dmem_we    <= op_is_store(mem_op);
                dmem_addr  <= {alu_result[31:2], 2'b00};
                dmem_be    <= lane_be(mem_op, alu_result[1:0]);
                dmem_wdata <= lane_wdata(mem_op, store_data);
            end
            if (state == REQ && state_nxt != REQ) begin
                dmem_req <= 1'b0;
            end
            if (fin_none) begin
                wb_valid <= 1'b1;
                wb_q     <= '{rd: rd_in, we: reg_we_in, data: alu_result};
            end
            if (fin_mis) begin
                wb_valid     <= 1'b1;
                misalign_exc <= 1'b1;
                wb_q.rd      <= rd_in;
                wb_q.we      <= 1'b0;
            end
            if (fin_store || fin_tmo) begin
                wb_valid <= 1'b1;
                wb_q.rd  <= rd_q;
                wb_q.we  <= 1'b0;
                bus_err  <= fin_tmo;
            end
            if (fin_load) begin
                wb_valid  <= 1'b1;
                wb_q.rd   <= rd_q;
                wb_q.we   <= we_q;
                wb_q.data <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: driver pushes expected writebacks, a monitor pops them on wb_valid.
// A byte-lane reference model computes bus fields and load results arithmetically.
module tb_mem_access;
    import rv32i_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    mem_op_t     mem_op;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd_in;
    logic        reg_we_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_we, misalign_exc, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .mem_op(mem_op), .alu_result(alu_result), .store_data(store_data),
        .rd_in(rd_in), .reg_we_in(reg_we_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    typedef struct {
        logic        mis;
        logic        berr;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int op_size(mem_op_t op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_SW:          return 4;
            default:                 return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(mem_op_t op, int lo, logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (8 * lo)) & 32'hFFFF;
        case (op)
            MEM_LB:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            MEM_LH:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            MEM_LBU: return b;
            MEM_LHU: return h;
            default: return w;
        endcase
    endfunction

    // Monitor: every wb_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wb", 32'(wb_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wb_misalign", 32'(misalign_exc), 32'(e.mis));
                    check("wb_bus_err",  32'(bus_err),      32'(e.berr));
                    check("wb_we",       32'(wb_we),        32'(e.we));
                    if (e.chk_data) begin
                        check("wb_rd",   32'(wb_rd), 32'(e.rd));
                        check("wb_data", wb_data,    e.data);
                    end
                end
            end else begin
                check("qualifier_idle", {30'd0, misalign_exc, bus_err}, 32'd0);
            end
        end
    end

    task automatic do_txn(mem_op_t op, logic [31:0] addr, logic [31:0] sd, logic [4:0] rd,
                          logic we, int gw, int rw, logic [31:0] rdata);
        int          sz, lo;
        bit          is_st, is_ld, mis, granted, done;
        exp_t        e;
        logic [3:0]  be_e;
        logic [31:0] wd_e;
        sz    = op_size(op);
        lo    = int'(addr % 4);
        is_st = op inside {MEM_SB, MEM_SH, MEM_SW};
        is_ld = (sz > 0) && !is_st;
        mis   = (sz > 0) && ((addr % sz) != 0);
        be_e  = 4'(((1 << sz) - 1) << lo);
        wd_e  = (sz == 1) ? {24'd0, sd[7:0]} * 32'h0101_0101 :
                (sz == 2) ? {16'd0, sd[15:0]} * 32'h0001_0001 : sd;
        e.mis = 1'b0; e.berr = 1'b0; e.we = 1'b0; e.rd = rd; e.data = '0; e.chk_data = 1'b0;
        if (sz == 0) begin
            e.we = we; e.data = addr; e.chk_data = 1'b1;
        end else if (mis) begin
            e.mis = 1'b1;
        end else if (gw >= TMO || (is_ld && rw >= 1 && rw - 1 >= TMO)) begin
            e.berr = 1'b1;
        end else if (is_ld) begin
            e.we = we; e.data = model_load(op, lo, rdata); e.chk_data = 1'b1;
        end
        exp_q.push_back(e);

        @(negedge clk);
        valid_in = 1'b1; mem_op = op; alu_result = addr; store_data = sd;
        rd_in = rd; reg_we_in = we;
        @(negedge clk);
        valid_in = 1'b0;
        if (sz == 0 || mis) begin
            check("fast_wb_latency", 32'(wb_valid), 32'd1);
            check("fast_no_req",     32'(dmem_req), 32'd0);
            check("fast_ready",      32'(ready_out), 32'd1);
            return;
        end

        granted = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            check("req_held",  32'(dmem_req),  32'd1);
            check("req_ready", 32'(ready_out), 32'd0);
            check("req_addr",  dmem_addr, addr & 32'hFFFF_FFFC);
            check("req_be",    32'(dmem_be), 32'(be_e));
            check("req_we",    32'(dmem_we), 32'(is_st));
            if (is_st) check("req_wdata", dmem_wdata, wd_e);
            if (k == gw) begin
                dmem_gnt = 1'b1;
                if (is_ld && rw == 0) begin
                    dmem_rvalid = 1'b1; dmem_rdata = rdata;
                end
            end
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (k == gw) begin
                granted = 1'b1;
                break;
            end
        end

        if (granted && is_ld && rw > 0) begin
            done = 1'b0;
            for (int k = 0; k < TMO && !done; k++) begin
                check("resp_req_low", 32'(dmem_req),  32'd0);
                check("resp_ready",   32'(ready_out), 32'd0);
                if (k == rw - 1) begin
                    dmem_rvalid = 1'b1; dmem_rdata = rdata;
                    done = 1'b1;
                end
                @(negedge clk);
                dmem_rvalid = 1'b0;
            end
        end
        check("done_wb_latency", 32'(wb_valid),  32'd1);
        check("done_req_low",    32'(dmem_req),  32'd0);
        check("done_ready",      32'(ready_out), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_op_t     op;
        logic [31:0] a;
        int          sz;
        rst = 1'b0; valid_in = 1'b0; mem_op = MEM_NONE; alu_result = '0; store_data = '0;
        rd_in = '0; reg_we_in = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {dmem_req, dmem_we, dmem_be, wb_valid, wb_we, misalign_exc, bus_err, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_addr",    dmem_addr, 32'd0);
        check("rst_ready",   32'(ready_out), 32'd1);
        rst = 1'b1;

        do_txn(MEM_NONE, 32'h1234_5678, 32'd0, 5'd5, 1'b1, 0, 0, 32'd0);
        do_txn(MEM_LB,   32'h0000_0103, 32'd0, 5'd9, 1'b1, 2, 1, 32'h80FF_FFFF);
        do_txn(MEM_SH,   32'h0000_0202, 32'h0000_ABCD, 5'd3, 1'b1, 0, 0, 32'd0);
        do_txn(MEM_LW,   32'h0000_0301, 32'd0, 5'd4, 1'b1, 0, 0, 32'd0);
        do_txn(MEM_LW,   32'h0000_0400, 32'd0, 5'd6, 1'b1, 99, 0, 32'd0);
        do_txn(MEM_LH,   32'h0000_0402, 32'd0, 5'd7, 1'b1, TMO - 1, TMO, 32'h8123_4567);
        do_txn(MEM_LHU,  32'h0000_0406, 32'd0, 5'd8, 1'b1, 1, TMO + 1, 32'h1111_2222);

        // Reset while in REQ must drop dmem_req on the reset edge.
        @(negedge clk);
        valid_in = 1'b1; mem_op = MEM_LW; alu_result = 32'h0000_0500; rd_in = 5'd2; reg_we_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        check("req_before_rst", 32'(dmem_req), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("req_dropped_by_rst", 32'(dmem_req), 32'd0);

        // LHU reset in RESP, then a late rvalid that must be ignored.
        @(negedge clk);
        valid_in = 1'b1; mem_op = MEM_LHU; alu_result = 32'h0000_0602; rd_in = 5'd11; reg_we_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("resp_entered", 32'(ready_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid_outputs", {dmem_req, dmem_we, dmem_be, wb_valid, wb_we, misalign_exc, bus_err, wb_rd}, 32'd0);
        check("rst_mid_wb_data", wb_data, 32'd0);
        check("rst_mid_ready",   32'(ready_out), 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("late_rvalid_ignored", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check("late_rvalid_ignored2", 32'(wb_valid), 32'd0);

        for (int i = 0; i < 200; i++) begin
            op = mem_op_t'($urandom_range(0, 8));
            a  = $urandom;
            sz = op_size(op);
            if (sz > 0 && $urandom_range(0, 3) != 0) a = a & ~(32'(sz) - 32'd1);
            do_txn(op, a, $urandom, 5'($urandom), 1'($urandom),
                   $urandom_range(0, TMO + 1), $urandom_range(0, TMO + 1), $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
